ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-client round-robin arbiter that shares the single read/write port (addr/data/we, registered read data) of the team's dual-port RAM.
- Each client issues single-beat read or write requests. The block serialises them, drives the RAM port, and returns read data with a valid strobe to the client that issued the read.
- Sits between the two producer/consumer engines and the RAM. All logic runs in the single fast clock domain.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDRESS_WIDTH, 8, RAM address width (depth 2**ADDRESS_WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
c0_req  in  1  client 0 request, held until c0_ack
c0_we  in  1  client 0 op: 1 write, 0 read
c0_addr  in  ADDRESS_WIDTH  client 0 address
c0_wdata  in  DATA_WIDTH  client 0 write data
c0_ack  out  1  one-cycle pulse: client 0 request issued to RAM
c0_rvalid  out  1  one-cycle pulse: c0_rdata valid
c0_rdata  out  DATA_WIDTH  read data for client 0
c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rvalid, c1_rdata: same as client 0, for client 1
ram_addr  out  ADDRESS_WIDTH  RAM port address
ram_data  out  DATA_WIDTH  RAM port write data
ram_we  out  1  RAM port op: 1 write, 0 read
ram_q  in  DATA_WIDTH  RAM registered read data, valid 1 cycle after a read is presented
busy  out  1  high while an issue or read return is in flight

Behaviour:
- Reset (rst high at clock edge): all outputs go to 0, priority pointer goes to client 0, and the read-return pipeline is flushed. A read in flight when reset hits never produces rvalid.
- Eligibility: client k is eligible in cycle N if ck_req=1 and ck_ack=0 in cycle N. Masking the acked client stops a still-held req from being issued twice.
- Arbitration in cycle N:
  - Both eligible: the client named by the pointer wins.
  - One eligible: that client wins.
  - After any grant, the pointer moves to the other client (strict alternation under contention, no starvation).
- Issue, cycle N+1 (all outputs registered):
  - ram_addr, ram_data and ram_we take the winner's addr, wdata and we.
  - The winner's ack is 1 for exactly this cycle.
- Idle cycles: ram_we=0. ram_addr and ram_data hold their previous values. No rvalid is generated.
- Read return:
  - A read issued in cycle N+1 makes the RAM register ram_q at the end of N+1.
  - In cycle N+2: ck_rvalid=1 for the issuing client only, and ck_rdata = ram_q, registered into a per-client holding register.
  - ck_rdata holds its value until that client's next rvalid.
  - The owner is tracked by a 2-stage tag pipeline (valid, client id).
- Writes: the RAM commits at the end of the issue cycle. A read issued in the following cycle, from either client, returns the new data.
- Latency: request to ack is 1 cycle. Request to rvalid is 2 cycles.
- Throughput:
  - One RAM op per cycle when both clients hold requests (alternating issue).
  - A single client alone gets one op every 2 cycles, because of the ack mask.
- Client rules: req, we, addr and wdata stay stable from assertion through the ack cycle. A client may drop req or present a new request in the cycle after ack. Dropping req before ack is allowed; the request is then simply not issued.
- busy = any ack high OR any read tag valid in the pipeline.
- State machine: none beyond the pointer bit. Valid states are pointer ∈ {0,1} × tag pipeline {empty, rd0, rd1} per stage.

Test Plan:
- Reset mid-read: c0 reads addr 0x10, rst asserted in the rvalid-pending cycle -> c0_rvalid never pulses; afterwards ram_we=0, all acks 0, pointer=0.
- Single client write then read: c0 writes 0xA5 to 0x20, then reads 0x20 -> c0_ack 1 cycle after each req; c0_rvalid 2 cycles after the read req with c0_rdata=0xA5; c1 outputs stay 0.
- Simultaneous contention: both clients request reads in the same cycle (c0 addr 0x01, c1 addr 0x02) after reset -> c0 acked first, c1 next cycle. c0_rvalid/0x01 data, then c1_rvalid/0x02 data on consecutive cycles.
- Sustained contention fairness: both hold req for 20 cycles with new addresses after each ack -> acks strictly alternate, 10 each, ram_we/ram_addr match the granted client every cycle.
- Cross-client RAW: c1 writes 0x3C to 0x40; c0 read of 0x40 pending at the same time -> if c1 is granted first, c0 reads 0x3C; if c0 is granted first, c0 reads the old value. The bench checks against the pointer-predicted order.
- Request withdrawal: c1 asserts req for 1 cycle while losing to c0, then drops it -> no c1_ack, no RAM op for c1, busy falls 2 cycles after c0's read issue.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-client round-robin arbiter for a single RAM read/write port.
// The winner is issued one cycle after its request, and its read data returns one cycle later.
module ram_port_arbiter #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     c0_req,
   input  logic                     c0_we,
   input  logic [ADDRESS_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0]    c0_wdata,
   output logic                     c0_ack,
   output logic                     c0_rvalid,
   output logic [DATA_WIDTH-1:0]    c0_rdata,
   input  logic                     c1_req,
   input  logic                     c1_we,
   input  logic [ADDRESS_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0]    c1_wdata,
   output logic                     c1_ack,
   output logic                     c1_rvalid,
   output logic [DATA_WIDTH-1:0]    c1_rdata,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_data,
   output logic                     ram_we,
   input  logic [DATA_WIDTH-1:0]    ram_q,
   output logic                     busy
);

   localparam logic PTR_C0 = 1'b0;
   localparam logic PTR_C1 = 1'b1;

   logic                  ptr;
   logic                  elig0, elig1;
   logic                  grant0, grant1;
   logic                  tag1_valid, tag1_id;
   logic                  tag2_valid, tag2_id;
   logic [DATA_WIDTH-1:0] hold0, hold1;

   // A client in its ack cycle is masked so a still-held req is not issued twice.
   always_comb begin
      elig0  = c0_req & ~c0_ack;
      elig1  = c1_req & ~c1_ack;
      grant0 = elig0 & (~elig1 | (ptr == PTR_C0));
      grant1 = elig1 & (~elig0 | (ptr == PTR_C1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= PTR_C0;
         c0_ack     <= 1'b0;
         c1_ack     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_data   <= '0;
         tag1_valid <= 1'b0;
         tag1_id    <= 1'b0;
         tag2_valid <= 1'b0;
         tag2_id    <= 1'b0;
         hold0      <= '0;
         hold1      <= '0;
      end else begin
         c0_ack <= grant0;
         c1_ack <= grant1;
         ram_we <= 1'b0;
         if (grant0) begin
            ram_addr <= c0_addr;
            ram_data <= c0_wdata;
            ram_we   <= c0_we;
            ptr      <= PTR_C1;
         end else if (grant1) begin
            ram_addr <= c1_addr;
            ram_data <= c1_wdata;
            ram_we   <= c1_we;
            ptr      <= PTR_C0;
         end
         // Stage 1 covers the issue cycle, stage 2 the cycle ram_q is valid.
         tag1_valid <= (grant0 & ~c0_we) | (grant1 & ~c1_we);
         tag1_id    <= grant1;
         tag2_valid <= tag1_valid;
         tag2_id    <= tag1_id;
         if (c0_rvalid) hold0 <= ram_q;
         if (c1_rvalid) hold1 <= ram_q;
      end
   end

   assign c0_rvalid = tag2_valid & ~tag2_id;
   assign c1_rvalid = tag2_valid & tag2_id;
   // ram_q is only valid in the return cycle, so it bypasses the holding register then.
   assign c0_rdata  = c0_rvalid ? ram_q : hold0;
   assign c1_rdata  = c1_rvalid ? ram_q : hold1;
   assign busy      = c0_ack | c1_ack | tag1_valid | tag2_valid;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-read RAM.
// The RAM preloads mem[i] = i ^ 0x5A on its first clock edge.
module tb_ram_port_arbiter;

   bit         clk = 1'b0;
   logic       rst;
   logic       c0_req, c0_we, c0_ack, c0_rvalid;
   logic [7:0] c0_addr, c0_wdata, c0_rdata;
   logic       c1_req, c1_we, c1_ack, c1_rvalid;
   logic [7:0] c1_addr, c1_wdata, c1_rdata;
   logic [7:0] ram_addr, ram_data, ram_q;
   logic       ram_we, busy;

   logic [7:0] mem [256];
   bit         mem_init = 1'b0;

   int checks = 0;
   int errors = 0;
   int n0, n1, cnt0, cnt1;
   logic exp1;

   always #5 clk = ~clk;

   ram_port_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_ack(c0_ack), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
      .busy(busy)
   );

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         mem_init <= 1'b1;
         ram_q    <= 8'h00;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_data;
         ram_q <= mem[ram_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      c0_req = 1'b0; c0_we = 1'b0; c0_addr = 8'h00; c0_wdata = 8'h00;
      c1_req = 1'b0; c1_we = 1'b0; c1_addr = 8'h00; c1_wdata = 8'h00;
      tick;
      tick;
      chk1("rst_ram_we", ram_we, 1'b0);
      chk1("rst_c0_ack", c0_ack, 1'b0);
      chk1("rst_c1_ack", c1_ack, 1'b0);
      chk1("rst_c0_rvalid", c0_rvalid, 1'b0);
      chk1("rst_c1_rvalid", c1_rvalid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_ram_addr", ram_addr, 8'h00);
      chk8("rst_c0_rdata", c0_rdata, 8'h00);

      // Reset lands while a c0 read is waiting for its return cycle.
      rst = 1'b0;
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 8'h10;
      tick;
      chk1("mid_c0_ack", c0_ack, 1'b1);
      chk8("mid_ram_addr", ram_addr, 8'h10);
      rst = 1'b1;
      tick;
      c0_req = 1'b0;
      chk1("mid_c0_rvalid", c0_rvalid, 1'b0);
      chk1("mid_c0_ack_low", c0_ack, 1'b0);
      chk1("mid_ram_we", ram_we, 1'b0);
      chk1("mid_busy", busy, 1'b0);
      chk8("mid_ram_addr_rst", ram_addr, 8'h00);
      tick;
      chk1("mid_c0_rvalid2", c0_rvalid, 1'b0);
      rst = 1'b0;

      // Contention straight after reset: pointer favours c0.
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 8'h01;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = 8'h02;
      tick;
      chk1("ct_c0_ack", c0_ack, 1'b1);
      chk1("ct_c1_ack_lo", c1_ack, 1'b0);
      chk8("ct_addr0", ram_addr, 8'h01);
      tick;
      c0_req = 1'b0;
      chk1("ct_c1_ack", c1_ack, 1'b1);
      chk1("ct_c0_ack_lo", c0_ack, 1'b0);
      chk8("ct_addr1", ram_addr, 8'h02);
      chk1("ct_c0_rvalid", c0_rvalid, 1'b1);
      chk8("ct_c0_rdata", c0_rdata, 8'h5B);
      chk1("ct_c1_rvalid_lo", c1_rvalid, 1'b0);
      tick;
      c1_req = 1'b0;
      chk1("ct_c1_rvalid", c1_rvalid, 1'b1);
      chk8("ct_c1_rdata", c1_rdata, 8'h58);
      chk1("ct_c0_rvalid_lo", c0_rvalid, 1'b0);
      chk8("ct_c0_rdata_hold", c0_rdata, 8'h5B);
      tick;
      chk1("ct_c1_rvalid_end", c1_rvalid, 1'b0);
      chk1("ct_busy_end", busy, 1'b0);
      chk8("ct_c1_rdata_hold", c1_rdata, 8'h58);

      // Single client: write 0xA5 to 0x20, then read it back.
      c0_req = 1'b1; c0_we = 1'b1; c0_addr = 8'h20; c0_wdata = 8'hA5;
      tick;
      chk1("wr_c0_ack", c0_ack, 1'b1);
      chk1("wr_ram_we", ram_we, 1'b1);
      chk8("wr_ram_addr", ram_addr, 8'h20);
      chk8("wr_ram_data", ram_data, 8'hA5);
      chk1("wr_c1_ack", c1_ack, 1'b0);
      tick;
      c0_we = 1'b0;
      chk1("idle_c0_ack", c0_ack, 1'b0);
      chk1("idle_ram_we", ram_we, 1'b0);
      chk8("idle_ram_addr", ram_addr, 8'h20);
      chk8("idle_ram_data", ram_data, 8'hA5);
      tick;
      chk1("rd_c0_ack", c0_ack, 1'b1);
      chk1("rd_ram_we", ram_we, 1'b0);
      chk8("rd_ram_addr", ram_addr, 8'h20);
      tick;
      c0_req = 1'b0;
      chk1("rd_c0_rvalid", c0_rvalid, 1'b1);
      chk8("rd_c0_rdata", c0_rdata, 8'hA5);
      chk1("rd_c1_rvalid", c1_rvalid, 1'b0);
      chk1("rd_c1_ack", c1_ack, 1'b0);
      tick;
      chk1("rd_c0_rvalid_end", c0_rvalid, 1'b0);
      chk8("rd_c0_rdata_hold", c0_rdata, 8'hA5);
      chk1("rd_busy_end", busy, 1'b0);

      // Sustained contention; pointer now names c1, so c1 is granted first.
      n0 = 0; n1 = 0; cnt0 = 0; cnt1 = 0;
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 8'h80;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 8'hC0; c1_wdata = 8'h30;
      for (int i = 1; i <= 20; i++) begin
         tick;
         exp1 = (i % 2) == 1;
         chk1("fair_c1_ack", c1_ack, exp1);
         chk1("fair_c0_ack", c0_ack, ~exp1);
         chk1("fair_ram_we", ram_we, exp1);
         if (exp1) begin
            chk8("fair_addr1", ram_addr, 8'hC0 + 8'(n1));
            chk8("fair_data1", ram_data, 8'h30 + 8'(n1));
         end else begin
            chk8("fair_addr0", ram_addr, 8'h80 + 8'(n0));
         end
         cnt0 += int'(c0_ack);
         cnt1 += int'(c1_ack);
         if ((i % 2) == 1 && i >= 2) begin
            n0++;
            c0_addr = 8'h80 + 8'(n0);
         end else if ((i % 2) == 0) begin
            if (i == 20) begin
               c1_req = 1'b0;
            end else begin
               n1++;
               c1_addr  = 8'hC0 + 8'(n1);
               c1_wdata = 8'h30 + 8'(n1);
            end
         end
      end
      tick;
      c0_req = 1'b0;
      chk1("fair_tail_c0_ack", c0_ack, 1'b0);
      chk1("fair_tail_c1_ack", c1_ack, 1'b0);
      chk8("fair_cnt0", 8'(cnt0), 8'd10);
      chk8("fair_cnt1", 8'(cnt1), 8'd10);
      tick;

      // RAW across clients, c1 write granted first: c0 sees the new data.
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 8'h40;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 8'h40; c1_wdata = 8'h3C;
      tick;
      chk1("raw1_c1_ack", c1_ack, 1'b1);
      chk1("raw1_c0_ack_lo", c0_ack, 1'b0);
      chk1("raw1_ram_we", ram_we, 1'b1);
      chk8("raw1_ram_data", ram_data, 8'h3C);
      tick;
      c1_req = 1'b0;
      chk1("raw1_c0_ack", c0_ack, 1'b1);
      chk1("raw1_rd_we", ram_we, 1'b0);
      chk8("raw1_rd_addr", ram_addr, 8'h40);
      tick;
      c0_req = 1'b0;
      chk1("raw1_c0_rvalid", c0_rvalid, 1'b1);
      chk8("raw1_c0_rdata", c0_rdata, 8'h3C);
      tick;

      // Reset returns the pointer to c0, so c0 reads before c1 writes: old data.
      rst = 1'b1;
      tick;
      rst = 1'b0;
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 8'h40;
      c1_req = 1'b1; c1_we = 1'b1; c1_addr = 8'h40; c1_wdata = 8'h77;
      tick;
      chk1("raw2_c0_ack", c0_ack, 1'b1);
      chk1("raw2_c1_ack_lo", c1_ack, 1'b0);
      chk1("raw2_ram_we", ram_we, 1'b0);
      tick;
      c0_req = 1'b0;
      chk1("raw2_c1_ack", c1_ack, 1'b1);
      chk1("raw2_wr_we", ram_we, 1'b1);
      chk8("raw2_wr_data", ram_data, 8'h77);
      chk1("raw2_c0_rvalid", c0_rvalid, 1'b1);
      chk8("raw2_c0_rdata", c0_rdata, 8'h3C);
      tick;
      c1_req = 1'b0;
      chk1("raw2_c0_rvalid_end", c0_rvalid, 1'b0);
      tick;

      // c1 requests for a single cycle while losing to c0, then withdraws.
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 8'h01;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = 8'h02;
      tick;
      c1_req = 1'b0;
      chk1("wd_c0_ack", c0_ack, 1'b1);
      chk1("wd_c1_ack_a", c1_ack, 1'b0);
      chk1("wd_busy_a", busy, 1'b1);
      chk8("wd_ram_addr_a", ram_addr, 8'h01);
      tick;
      c0_req = 1'b0;
      chk1("wd_c1_ack_b", c1_ack, 1'b0);
      chk1("wd_ram_we_b", ram_we, 1'b0);
      chk8("wd_ram_addr_b", ram_addr, 8'h01);
      chk1("wd_busy_b", busy, 1'b1);
      chk1("wd_c0_rvalid", c0_rvalid, 1'b1);
      chk8("wd_c0_rdata", c0_rdata, 8'h5B);
      tick;
      chk1("wd_busy_c", busy, 1'b0);
      chk1("wd_c1_ack_c", c1_ack, 1'b0);
      chk1("wd_c1_rvalid_c", c1_rvalid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
